digit_frame_streamer: RTL and testbench

Sequencer that renders a row of 7-segment digits into SSD1306 page bytes. It scans digit, page and column indices and drives them to a 21x32 digit pixel decoder. It reads back the decoder's combinational pixel byte and streams the result, in horizontal-addressing order, over a valid/ready byte interface to the OLED SPI/I2C transmitter. It sits between the digit/segment register bank and the display transport, and produces exactly one frame per `start` pulse.

---
 rtl/digit_frame_streamer.sv | 122 ++++++++++++
 tb/tb_digit_frame_streamer.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/digit_frame_streamer.sv
// Renders a row of 7-segment digits into SSD1306 page bytes: scans page/digit/column indices
// for a combinational pixel decoder and streams the bytes over a valid/ready interface.
module digit_frame_streamer #(
   parameter int unsigned NUM_DIGITS  = 6,
   parameter int unsigned DIGIT_WIDTH = 21,
   parameter int unsigned DIGIT_PAGES = 4,
   parameter int unsigned GAP_COLUMNS = 3,
   parameter int unsigned SEL_W       = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
   input  logic             clk_i,
   input  logic             reset_i,
   input  logic             start_i,
   output logic             busy_o,
   output logic             done_o,
   output logic [SEL_W-1:0] digit_sel_o,
   output logic [4:0]       index_x_o,
   output logic [1:0]       index_y_o,
   input  logic [7:0]       pixels_in_i,
   output logic [7:0]       out_data_o,
   output logic             out_valid_o,
   input  logic             out_ready_i
);

   localparam logic [4:0]       ColLast  = 5'(DIGIT_WIDTH + GAP_COLUMNS - 1);
   localparam logic [4:0]       ColGap   = 5'(DIGIT_WIDTH);
   localparam logic [SEL_W-1:0] DigLast  = SEL_W'(NUM_DIGITS - 1);
   localparam logic [1:0]       PageLast = 2'(DIGIT_PAGES - 1);

   typedef enum logic [1:0] {StIdle, StFetch, StSend, StDone} state_e;

   state_e           state_q, state_d;
   logic [4:0]       col_q, col_d;
   logic [SEL_W-1:0] dig_q, dig_d;
   logic [1:0]       page_q, page_d;
   logic [7:0]       out_data_q, out_data_d;
   logic             out_valid_q, out_valid_d;
   logic             last_byte;
   logic             gap_col;

   assign last_byte = (col_q == ColLast) && (dig_q == DigLast) && (page_q == PageLast);
   assign gap_col   = (col_q >= ColGap);

   always_comb begin
      state_d     = state_q;
      col_d       = col_q;
      dig_d       = dig_q;
      page_d      = page_q;
      out_data_d  = out_data_q;
      out_valid_d = out_valid_q;
      unique case (state_q)
         StIdle: begin
            if (start_i) begin
               col_d   = '0;
               dig_d   = '0;
               page_d  = '0;
               state_d = StFetch;
            end
         end
         StFetch: begin
            // Indices have been stable for this whole cycle, so the decoder byte has settled.
            out_data_d  = gap_col ? 8'h00 : pixels_in_i;
            out_valid_d = 1'b1;
            state_d     = StSend;
         end
         StSend: begin
            if (out_valid_q && out_ready_i) begin
               out_valid_d = 1'b0;
               if (last_byte) begin
                  state_d = StDone;
               end else begin
                  state_d = StFetch;
                  if (col_q == ColLast) begin
                     col_d = '0;
                     if (dig_q == DigLast) begin
                        dig_d  = '0;
                        page_d = page_q + 2'd1;
                     end else begin
                        dig_d = dig_q + SEL_W'(1);
                     end
                  end else begin
                     col_d = col_q + 5'd1;
                  end
               end
            end
         end
         StDone: begin
            col_d   = '0;
            dig_d   = '0;
            page_d  = '0;
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_q     <= StIdle;
         col_q       <= '0;
         dig_q       <= '0;
         page_q      <= '0;
         out_data_q  <= 8'h00;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         col_q       <= col_d;
         dig_q       <= dig_d;
         page_q      <= page_d;
         out_data_q  <= out_data_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign busy_o      = (state_q != StIdle);
   assign done_o      = (state_q == StDone);
   assign digit_sel_o = dig_q;
   assign index_x_o   = col_q;
   assign index_y_o   = page_q;
   assign out_data_o  = out_data_q;
   assign out_valid_o = out_valid_q;

endmodule

// File: tb/tb_digit_frame_streamer.sv
// Randomized self-checking bench for digit_frame_streamer: frame bytes are compared against an
// index-arithmetic model of the page-major emission order, plus latency/backpressure checks.
module tb_digit_frame_streamer;

   localparam int Nd = 6;
   localparam int Dw = 21;
   localparam int Dp = 4;
   localparam int Gc = 3;
   localparam int FrameBytes = Dp * Nd * (Dw + Gc);

   logic       clk;
   logic       reset;
   logic       start;
   logic       busy;
   logic       done;
   logic [2:0] digit_sel;
   logic [4:0] index_x;
   logic [1:0] index_y;
   logic [7:0] pixels;
   logic [7:0] out_data;
   logic       out_valid;
   logic       out_ready;

   logic       start2;
   logic       busy2;
   logic       done2;
   logic [0:0] sel2;
   logic [4:0] x2;
   logic [1:0] y2;
   logic [7:0] pixels2;
   logic [7:0] data2;
   logic       valid2;

   logic       ready_auto;
   logic       ready_man;
   logic       ready_rnd;
   logic [7:0] mask [8];

   logic [7:0] got_q [$];
   logic [7:0] got2_q [$];
   int         done_cnt;
   int         done2_cnt;
   int         sel2_bad;
   int         n_vec;
   int         n_err;

   digit_frame_streamer u_dut (
      .clk_i       (clk),
      .reset_i     (reset),
      .start_i     (start),
      .busy_o      (busy),
      .done_o      (done),
      .digit_sel_o (digit_sel),
      .index_x_o   (index_x),
      .index_y_o   (index_y),
      .pixels_in_i (pixels),
      .out_data_o  (out_data),
      .out_valid_o (out_valid),
      .out_ready_i (out_ready)
   );

   digit_frame_streamer #(
      .NUM_DIGITS  (1),
      .GAP_COLUMNS (0)
   ) u_dut_small (
      .clk_i       (clk),
      .reset_i     (reset),
      .start_i     (start2),
      .busy_o      (busy2),
      .done_o      (done2),
      .digit_sel_o (sel2),
      .index_x_o   (x2),
      .index_y_o   (y2),
      .pixels_in_i (pixels2),
      .out_data_o  (data2),
      .out_valid_o (valid2),
      .out_ready_i (out_ready)
   );

   // Decoder stub: {page, column, 1}, optionally scrambled per digit.
   assign pixels    = {index_y, index_x, 1'b1} ^ mask[digit_sel];
   assign pixels2   = {y2, x2, 1'b1} ^ mask[{2'b00, sel2}];
   assign out_ready = ready_auto ? ready_rnd : ready_man;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      #1;
      ready_rnd = ($urandom_range(0, 1) == 1);
   end

   always @(negedge clk) begin
      if (!reset) begin
         if (out_valid && out_ready) got_q.push_back(out_data);
         if (done) done_cnt++;
         if (valid2 && out_ready) begin
            got2_q.push_back(data2);
            if (sel2 != 1'b0) sel2_bad++;
         end
         if (done2) done2_cnt++;
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
      $fatal(1);
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_vec++;
      if (got !== want) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, want);
      end
   endtask

   // Byte k of a frame, derived from its position in page-major / digit / column order.
   function automatic logic [7:0] model_byte(input int k, input int nd, input int w, input int g);
      int span;
      int col;
      int dig;
      int page;
      span = w + g;
      col  = k % span;
      dig  = (k / span) % nd;
      page = k / (span * nd);
      if (col >= w) return 8'h00;
      return {page[1:0], col[4:0], 1'b1} ^ mask[dig];
   endfunction

   task automatic run_frame(input bit mid_start, input bit done_start, input bit bp,
                            input int want_cyc, input string name);
      int  cnt;
      int  base;
      int  dbase;
      int  busy_bad;
      bit  seen;
      bit  bp_done;
      base     = got_q.size();
      dbase    = done_cnt;
      busy_bad = 0;
      seen     = 1'b0;
      bp_done  = 1'b0;
      cnt      = 0;
      start    = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      check_eq({name, "_fetch"}, {busy, out_valid, digit_sel, index_x, index_y},
               {1'b1, 1'b0, 10'd0});
      while (!seen && cnt < 20000) begin
         @(posedge clk);
         cnt++;
         #1;
         if (cnt == 1)
            check_eq({name, "_first"}, {out_valid, out_data}, {1'b1, model_byte(0, Nd, Dw, Gc)});
         if (mid_start) start = (cnt == 300);
         if (!busy) busy_bad++;
         if (done) begin
            seen = 1'b1;
            if (done_start) start = 1'b1;
         end else if (bp && !bp_done && out_valid && index_y == 2'd0 && digit_sel == 3'd0
                      && index_x == 5'd10) begin
            bp_done   = 1'b1;
            ready_man = 1'b0;
            for (int i = 0; i < 5; i++) begin
               @(posedge clk);
               cnt++;
               #1;
               check_eq($sformatf("bp_hold%0d", i),
                        {out_valid, out_data, digit_sel, index_x, index_y},
                        {1'b1, model_byte(10, Nd, Dw, Gc), 3'd0, 5'd10, 2'd0});
            end
            ready_man = 1'b1;
            @(posedge clk);
            cnt++;
            #1;
            check_eq("bp_release", {31'd0, out_valid}, 32'd0);
            @(posedge clk);
            cnt++;
            #1;
            check_eq("bp_byte11", {out_valid, out_data, index_x},
                     {1'b1, model_byte(11, Nd, Dw, Gc), 5'd11});
         end
      end
      if (!seen) check_eq({name, "_timeout"}, 32'd0, 32'd1);
      else if (want_cyc > 0) check_eq({name, "_cycles"}, cnt, want_cyc);
      if (bp) check_eq("bp_seen", {31'd0, bp_done}, 32'd1);
      check_eq({name, "_busy_span"}, busy_bad, 0);
      @(posedge clk);
      #1;
      start = 1'b0;
      check_eq({name, "_idle"}, {busy, done}, 2'b00);
      check_eq({name, "_done_cnt"}, done_cnt - dbase, 1);
      check_eq({name, "_len"}, got_q.size() - base, FrameBytes);
      for (int k = 0; k < FrameBytes && base + k < got_q.size(); k++)
         check_eq($sformatf("%s_byte%0d", name, k), got_q[base + k],
                  model_byte(k, Nd, Dw, Gc));
   endtask

   initial begin
      int b1;
      int cnt;
      int dbase;
      int base2;
      int bb;
      bit seen;
      n_vec      = 0;
      n_err      = 0;
      done_cnt   = 0;
      done2_cnt  = 0;
      sel2_bad   = 0;
      reset      = 1'b0;
      start      = 1'b0;
      start2     = 1'b0;
      ready_auto = 1'b0;
      ready_man  = 1'b1;
      for (int i = 0; i < 8; i++) mask[i] = 8'h00;

      // Idle reset
      #2;
      reset = 1'b1;
      #1;
      check_eq("rst_init", {busy, done, out_valid, out_data, digit_sel, index_x, index_y},
               21'd0);
      repeat (3) @(posedge clk);
      #1;
      check_eq("rst_hold", {busy, done, out_valid, out_data, digit_sel, index_x, index_y},
               21'd0);
      check_eq("rst_small", {busy2, done2, valid2, data2, sel2, x2, y2}, 19'd0);
      reset = 1'b0;
      @(posedge clk);
      #1;

      // Plain frame, stray start mid-frame and on the DONE cycle
      b1 = got_q.size();
      run_frame(1'b1, 1'b1, 1'b0, 2 * FrameBytes, "f1");
      check_eq("f1_b0", got_q[b1], 8'h01);
      check_eq("f1_b21", got_q[b1 + 21], 8'h00);
      check_eq("f1_b24", got_q[b1 + 24], 8'h01);

      // Started in the IDLE cycle right after DONE, with a 5-cycle stall on byte 10
      run_frame(1'b0, 1'b0, 1'b1, 2 * FrameBytes + 5, "f2");

      // Random backpressure, random decoder content
      ready_auto = 1'b1;
      for (int f = 0; f < 3; f++) begin
         for (int i = 0; i < 8; i++) mask[i] = 8'($urandom);
         run_frame(1'b0, 1'b0, 1'b0, 0, $sformatf("rnd%0d", f));
      end
      ready_auto = 1'b0;

      // Reset mid-frame
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (51) @(posedge clk);
      #1;
      check_eq("rst_pre_valid", {31'd0, out_valid}, 32'd1);
      #1;
      reset = 1'b1;
      #1;
      check_eq("rst_mid", {busy, done, out_valid, out_data, digit_sel, index_x, index_y},
               21'd0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      dbase = done_cnt;
      repeat (1300) @(posedge clk);
      #1;
      check_eq("rst_no_done", done_cnt - dbase, 0);
      check_eq("rst_idle", {31'd0, busy}, 32'd0);
      run_frame(1'b0, 1'b0, 1'b0, 2 * FrameBytes, "post_rst");

      // Single digit, no gap columns
      for (int i = 0; i < 8; i++) mask[i] = 8'h00;
      base2  = got2_q.size();
      dbase  = done2_cnt;
      bb     = 0;
      cnt    = 0;
      seen   = 1'b0;
      start2 = 1'b1;
      @(posedge clk);
      #1;
      start2 = 1'b0;
      while (!seen && cnt < 2000) begin
         @(posedge clk);
         cnt++;
         #1;
         if (!busy2) bb++;
         if (done2) seen = 1'b1;
      end
      if (!seen) check_eq("small_timeout", 32'd0, 32'd1);
      else check_eq("small_cycles", cnt, 2 * 84);
      check_eq("small_busy_span", bb, 0);
      @(posedge clk);
      #1;
      check_eq("small_idle", {busy2, done2}, 2'b00);
      check_eq("small_done_cnt", done2_cnt - dbase, 1);
      check_eq("small_sel", sel2_bad, 0);
      check_eq("small_len", got2_q.size() - base2, 84);
      for (int k = 0; k < 84 && base2 + k < got2_q.size(); k++)
         check_eq($sformatf("small_byte%0d", k), got2_q[base2 + k], model_byte(k, 1, Dw, 0));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
